// File: rtl/mips_if_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   RESET_PC_DEF : value shown on id_pc while the entry queue is empty
//   PC_W/INST_W  : entry field widths
//   ptr_width()  : pointer width for a power-of-two queue depth (minimum 1)
package mips_if_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hbfc0_0000;
  localparam int          PC_W         = 32;
  localparam int          INST_W       = 32;

  function automatic int ptr_width(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    if (w == 0) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/if_entry_queue.sv
// In-order entry queue for the fetch stage. Each entry pairs a fetch PC
// with its instruction word and a filled flag.
//   alloc_i/alloc_pc_i  : reserve the entry at the allocation pointer
//   fill_i/fill_inst_i  : write the next unfilled entry (response order)
//   pop_i               : retire the head entry
//   flush_i             : empty the queue, all pointers jump to alloc pointer
//   count_o             : allocated entries (0..DEPTH)
//   unfilled_o          : allocated entries still waiting for data
//   head_*_o            : head entry view; head_valid_o = filled && count>0
// Optional (IF_ADEL_CHECK_EN): alloc_adel_i allocates a pre-filled entry
// with a zero instruction and an address-error flag, head_adel_o shows it.
module if_entry_queue
  import mips_if_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PW    = ptr_width(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_i,
  input  logic [PC_W-1:0]   alloc_pc_i,
`ifdef IF_ADEL_CHECK_EN
  input  logic              alloc_adel_i,
  output logic              head_adel_o,
`endif
  input  logic              fill_i,
  input  logic [INST_W-1:0] fill_inst_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [CW-1:0]     count_o,
  output logic [CW-1:0]     unfilled_o,
  output logic              head_valid_o,
  output logic [PC_W-1:0]   head_pc_o,
  output logic [INST_W-1:0] head_inst_o
);

  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [PC_W-1:0]   pc_d   [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [INST_W-1:0] inst_d [DEPTH];
  logic [DEPTH-1:0]  filled_q, filled_d;
  logic [PW-1:0]     alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]     fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]     head_ptr_q, head_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     filled_cnt;
`ifdef IF_ADEL_CHECK_EN
  logic [DEPTH-1:0]  adel_q, adel_d;
`endif

  always_comb begin
    pc_d        = pc_q;
    inst_d      = inst_q;
    filled_d    = filled_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    count_d     = count_q;
`ifdef IF_ADEL_CHECK_EN
    adel_d      = adel_q;
`endif
    if (flush_i) begin
      filled_d   = '0;
      count_d    = '0;
      head_ptr_d = alloc_ptr_q;
      fill_ptr_d = alloc_ptr_q;
    end else begin
      // Fill, pop and alloc always touch different entries: the fill target
      // is unfilled, the head is filled, and alloc only hits a free slot.
      if (fill_i) begin
        inst_d[fill_ptr_q]   = fill_inst_i;
        filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d           = fill_ptr_q + PTR_ONE;
      end
      if (pop_i) begin
        filled_d[head_ptr_q] = 1'b0;
        head_ptr_d           = head_ptr_q + PTR_ONE;
      end
      if (alloc_i) begin
        pc_d[alloc_ptr_q]     = alloc_pc_i;
        filled_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d           = alloc_ptr_q + PTR_ONE;
`ifdef IF_ADEL_CHECK_EN
        adel_d[alloc_ptr_q] = alloc_adel_i;
        // Address-error entries are only allocated with nothing pending on
        // the bus, so fill_ptr == alloc_ptr here and simply steps past it.
        if (alloc_adel_i) begin
          inst_d[alloc_ptr_q]   = '0;
          filled_d[alloc_ptr_q] = 1'b1;
          fill_ptr_d            = alloc_ptr_q + PTR_ONE;
        end
`endif
      end
      count_d = count_q + {{(CW-1){1'b0}}, alloc_i} - {{(CW-1){1'b0}}, pop_i};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filled_q    <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
`ifdef IF_ADEL_CHECK_EN
      adel_q      <= '0;
`endif
    end else begin
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      filled_q    <= filled_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      count_q     <= count_d;
`ifdef IF_ADEL_CHECK_EN
      adel_q      <= adel_d;
`endif
    end
  end

  // filled bits are only ever set on allocated entries, so the number of
  // entries still waiting for the bus is count minus the filled population.
  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filled_cnt = filled_cnt + {{(CW-1){1'b0}}, filled_q[i]};
    end
  end

  assign count_o      = count_q;
  assign unfilled_o   = count_q - filled_cnt;
  assign head_valid_o = filled_q[head_ptr_q] && (count_q != '0);
  assign head_pc_o    = pc_q[head_ptr_q];
  assign head_inst_o  = inst_q[head_ptr_q];
`ifdef IF_ADEL_CHECK_EN
  assign head_adel_o  = adel_q[head_ptr_q];
`endif

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage between the PC register and decode.
// Issues one read per accepted address, pairs returned words with their PC
// in an in-order queue, and advances the PC only on an address handshake.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   pc, pc_en        : current fetch PC in, PC advance enable out
//   flush            : drop all queued and in-flight fetches
//   inst_req/addr    : bus request valid and address (address == pc)
//   inst_addr_ok     : bus accepted the address this cycle
//   inst_data_ok     : read data valid this cycle, in request order
//   inst_rdata       : read data
//   id_valid/ready   : decode-facing handshake
//   id_pc/id_inst    : head entry (RESET_PC / 0 while the queue is empty)
//   id_adel          : only with IF_ADEL_CHECK_EN; misaligned-PC entry flag
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high (inst_req/inst_addr_ok, id_valid/id_ready); valid never waits on
// ready. inst_data_ok has no back-pressure.
// Build option: define IF_ADEL_CHECK_EN for the PC alignment check.
module if_fetch_stage
  import mips_if_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  localparam int         CW       = ptr_width(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_en,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
`ifdef IF_ADEL_CHECK_EN
  ,
  output logic        id_adel
`endif
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0]     count, unfilled;
  logic [CW-1:0]     discard_q, discard_d;
  logic [CW-1:0]     flush_total;
  logic [CW:0]       occupancy;
  logic              has_room, issue_ok;
  logic              alloc, fill, pop, head_valid, empty_view;
  logic [PC_W-1:0]   head_pc;
  logic [INST_W-1:0] head_inst;

  // Responses still owed for flushed requests also occupy queue budget, so
  // the bus never carries more than DEPTH outstanding reads.
  assign occupancy = {1'b0, count} + {1'b0, discard_q};
  assign has_room  = occupancy < (CW+1)'(DEPTH);
  assign issue_ok  = !reset && !flush && has_room;
  assign inst_addr = pc;

`ifdef IF_ADEL_CHECK_EN
  logic misaligned, adel_alloc, head_adel;
  assign misaligned = pc[1:0] != 2'b00;
  // Wait until the bus is idle so the pre-filled entry stays in response
  // order behind every real request.
  assign adel_alloc = issue_ok && misaligned && (unfilled == '0) && (discard_q == '0);
  assign inst_req   = issue_ok && !misaligned;
  assign alloc      = (inst_req && inst_addr_ok) || adel_alloc;
`else
  assign inst_req   = issue_ok;
  assign alloc      = inst_req && inst_addr_ok;
`endif
  assign pc_en = alloc;

  // A response with nothing to fill (e.g. stray after reset) is ignored.
  assign fill = inst_data_ok && !reset && !flush && (discard_q == '0) && (unfilled != '0);

  assign id_valid   = !reset && head_valid;
  assign pop        = id_valid && id_ready;
  assign empty_view = reset || (count == '0);
  assign id_pc      = empty_view ? RESET_PC : head_pc;
  assign id_inst    = empty_view ? 32'h0 : head_inst;
`ifdef IF_ADEL_CHECK_EN
  assign id_adel    = id_valid && head_adel;
`endif

  // On flush every unfilled entry becomes a response to drop; a response
  // arriving in the flush cycle itself already belongs to that stream.
  always_comb begin
    discard_d   = discard_q;
    flush_total = discard_q + unfilled;
    if (flush) begin
      discard_d = flush_total;
      if (inst_data_ok && (flush_total != '0)) discard_d = flush_total - CNT_ONE;
    end else if (inst_data_ok && (discard_q != '0)) begin
      discard_d = discard_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) discard_q <= '0;
    else       discard_q <= discard_d;
  end

  if_entry_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .reset        (reset),
    .alloc_i      (alloc),
    .alloc_pc_i   (pc),
`ifdef IF_ADEL_CHECK_EN
    .alloc_adel_i (adel_alloc),
    .head_adel_o  (head_adel),
`endif
    .fill_i       (fill),
    .fill_inst_i  (inst_rdata),
    .pop_i        (pop),
    .flush_i      (flush),
    .count_o      (count),
    .unfilled_o   (unfilled),
    .head_valid_o (head_valid),
    .head_pc_o    (head_pc),
    .head_inst_o  (head_inst)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'hbfc0_0000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_en;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
`ifdef IF_ADEL_CHECK_EN
  logic        id_adel;
`endif

  always #5 clk = ~clk;

  if_fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .pc_en        (pc_en),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_pc        (id_pc),
    .id_inst      (id_inst)
`ifdef IF_ADEL_CHECK_EN
    ,
    .id_adel      (id_adel)
`endif
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];     // hand-written {pc, inst} delivery order
  logic [31:0] mem_pend[$];  // addresses accepted by the bus, not yet answered
  bit          mem_data_en;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5a5a_a5a5;
  endfunction

  function automatic logic [63:0] pair(input logic [31:0] a);
    return {a, inst_of(a)};
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: note bus/PC handshakes at the negedge, then at posedge+1
  // advance the PC register model and present the next in-order response.
  task automatic tick();
    logic [31:0] nxt_pc;
    bit          was_rst;
    @(negedge clk);
    was_rst = reset;
    nxt_pc  = pc;
    if (reset) mem_pend.delete();
    else begin
      if (inst_req && inst_addr_ok) mem_pend.push_back(inst_addr);
      if (pc_en) nxt_pc = pc + 32'd4;
    end
    @(posedge clk);
    #1;
    pc = nxt_pc;
    if (!was_rst && mem_data_en && mem_pend.size() > 0) begin
      inst_data_ok = 1'b1;
      inst_rdata   = inst_of(mem_pend.pop_front());
    end else begin
      inst_data_ok = 1'b0;
      inst_rdata   = 32'hdead_beef;
    end
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    flush    = 1'b0;
    id_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
    id_ready = 1'b0;
  endtask

  // ---------------- reference model + compare ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          filled;
    bit          adel;
  } ent_t;

  ent_t mq[$];
  int   disc = 0;

  always @(negedge clk) begin : model_cmp
    bit          e_req, e_pen, e_valid, e_adel_alloc, mis, room, done;
    int          unf, tot;
    ent_t        e;
    logic [63:0] want;

    unf = 0;
    foreach (mq[i]) if (!mq[i].filled) unf++;
    mis = 1'b0;
`ifdef IF_ADEL_CHECK_EN
    mis = (pc[1:0] != 2'b00);
`endif
    room         = (mq.size() + disc) < DEPTH;
    e_req        = !reset && !flush && room && !mis;
    e_adel_alloc = !reset && !flush && room && mis && unf == 0 && disc == 0;
    e_pen        = (e_req && inst_addr_ok) || e_adel_alloc;
    e_valid      = !reset && mq.size() > 0 && mq[0].filled;

    chk("inst_req", {31'b0, inst_req}, {31'b0, e_req});
    chk("pc_en", {31'b0, pc_en}, {31'b0, e_pen});
    chk("id_valid", {31'b0, id_valid}, {31'b0, e_valid});
    chk("inst_addr", inst_addr, pc);
    if (e_valid) begin
      chk("id_pc", id_pc, mq[0].pc);
      chk("id_inst", id_inst, mq[0].inst);
`ifdef IF_ADEL_CHECK_EN
      chk("id_adel", {31'b0, id_adel}, {31'b0, mq[0].adel});
`endif
    end

    if (e_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL delivery: got pc %h expected no delivery", id_pc);
      end else begin
        want = exp_q.pop_front();
        chk("deliver_pc", id_pc, want[63:32]);
        chk("deliver_inst", id_inst, want[31:0]);
      end
    end

    // next state from the rules: in-order entries, responses fill the
    // oldest unfilled entry unless still owed to a flushed stream
    if (reset) begin
      mq.delete();
      disc = 0;
    end else if (flush) begin
      tot = disc + unf;
      if (inst_data_ok && tot > 0) tot--;
      disc = tot;
      mq.delete();
    end else begin
      if (inst_data_ok) begin
        if (disc > 0) disc--;
        else begin
          done = 1'b0;
          for (int i = 0; i < mq.size(); i++) begin
            if (!done && !mq[i].filled) begin
              mq[i].filled = 1'b1;
              mq[i].inst   = inst_rdata;
              done         = 1'b1;
            end
          end
        end
      end
      if (e_valid && id_ready) void'(mq.pop_front());
      if (e_pen) begin
        e.pc     = pc;
        e.inst   = 32'h0;
        e.filled = e_adel_alloc;
        e.adel   = e_adel_alloc;
        mq.push_back(e);
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    reset        = 1'b1;
    flush        = 1'b0;
    pc           = RST_PC;
    inst_addr_ok = 1'b1;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    id_ready     = 1'b1;
    mem_data_en  = 1'b1;

    // reset cycle outputs
    tick();
    #1;
    chk("rst_inst_req", {31'b0, inst_req}, 32'd0);
    chk("rst_pc_en", {31'b0, pc_en}, 32'd0);
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'hbfc0_0000);
    chk("rst_id_inst", id_inst, 32'h0);

    // zero-wait streaming from the reset vector
    reset = 1'b0;
    pc    = RST_PC;
    for (int i = 0; i < 8; i++) exp_q.push_back(pair(32'hbfc0_0000 + 32'(4 * i)));
    #1;
    chk("t1_first_req", {31'b0, inst_req}, 32'd1);
    chk("t1_first_addr", inst_addr, 32'hbfc0_0000);
    tick();
    #1;
    chk("t1_pc_step", pc, 32'hbfc0_0004);
    drain(60);

    // decode stall: queue fills after two allocations, PC holds
    apply_reset();
    reset       = 1'b0;
    pc          = RST_PC;
    mem_data_en = 1'b1;
    repeat (5) tick();
    #1;
    chk("t2_req_held", {31'b0, inst_req}, 32'd0);
    chk("t2_pc_en_held", {31'b0, pc_en}, 32'd0);
    chk("t2_pc_held", pc, 32'hbfc0_0008);
    chk("t2_head_pc", id_pc, 32'hbfc0_0000);
    for (int i = 0; i < 6; i++) exp_q.push_back(pair(32'hbfc0_0000 + 32'(4 * i)));
    id_ready = 1'b1;
    drain(60);

    // flush with two responses outstanding: both dropped
    apply_reset();
    reset       = 1'b0;
    pc          = RST_PC;
    mem_data_en = 1'b0;
    id_ready    = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    pc    = 32'h8000_0180;
    #1;
    chk("t3_flush_no_req", {31'b0, inst_req}, 32'd0);
    chk("t3_flush_no_pc_en", {31'b0, pc_en}, 32'd0);
    mem_data_en = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.push_back(pair(32'h8000_0180));
    exp_q.push_back(pair(32'h8000_0184));
    exp_q.push_back(pair(32'h8000_0188));
    #1;
    chk("t3_discard_full", {31'b0, inst_req}, 32'd0);
    drain(60);

    // flush in the same cycle as a response: only one more dropped
    apply_reset();
    reset       = 1'b0;
    pc          = RST_PC;
    mem_data_en = 1'b0;
    id_ready    = 1'b1;
    tick();
    mem_data_en = 1'b1;
    tick();
    flush = 1'b1;
    pc    = 32'h8000_0180;
    tick();
    flush = 1'b0;
    exp_q.push_back(pair(32'h8000_0180));
    exp_q.push_back(pair(32'h8000_0184));
    #1;
    chk("t4_valid_low", {31'b0, id_valid}, 32'd0);
    chk("t4_req_after", {31'b0, inst_req}, 32'd1);
    drain(60);

    // reset mid-stream with one buffered and one outstanding
    apply_reset();
    reset       = 1'b0;
    pc          = RST_PC;
    mem_data_en = 1'b1;
    tick();
    mem_data_en = 1'b0;
    tick();
    #1;
    chk("t5_pre_valid", {31'b0, id_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", {31'b0, id_valid}, 32'd0);
    chk("t5_rst_req", {31'b0, inst_req}, 32'd0);
    chk("t5_rst_id_pc", id_pc, 32'hbfc0_0000);
    tick();
    reset       = 1'b0;
    pc          = 32'h1000_0000;
    mem_data_en = 1'b1;
    id_ready    = 1'b1;
    exp_q.push_back(pair(32'h1000_0000));
    exp_q.push_back(pair(32'h1000_0004));
    #1;
    chk("t5_post_valid", {31'b0, id_valid}, 32'd0);
    chk("t5_post_req", {31'b0, inst_req}, 32'd1);
    chk("t5_post_addr", inst_addr, 32'h1000_0000);
    drain(60);

`ifdef IF_ADEL_CHECK_EN
    // misaligned PC: no bus request, pre-filled error entry
    apply_reset();
    reset = 1'b0;
    pc    = 32'hbfc0_0002;
    #1;
    chk("adel_no_req", {31'b0, inst_req}, 32'd0);
    chk("adel_pc_en", {31'b0, pc_en}, 32'd1);
    tick();
    #1;
    chk("adel_valid", {31'b0, id_valid}, 32'd1);
    chk("adel_flag", {31'b0, id_adel}, 32'd1);
    chk("adel_inst", id_inst, 32'h0);
    chk("adel_pc", id_pc, 32'hbfc0_0002);
    apply_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
